app_mul_pipe: RTL and testbench

Pipelined, parametrised Mitchell logarithmic approximate multiplier for the approximate-arithmetic datapath. It replaces the fixed 16-bit combinational unit with a generic-width, 3-stage, valid/ready pipeline. It adds a per-transaction signed/unsigned mode, an exact zero result, and a sideband tag. Results are full-width (2*WIDTH), and the pipeline sustains one operation per cycle under backpressure.

---
 rtl/app_mul_pipe.sv | 158 +++++++++++++++
 tb/tb_app_mul_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/app_mul_pipe.sv
// Three-stage valid/ready Mitchell logarithmic approximate multiplier.
// Supports signed/unsigned operation per transaction, an exact zero result, and a sideband tag.
module app_mul_pipe #(
    parameter int WIDTH     = 16,
    parameter int TAG_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_product,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int KW = $clog2(WIDTH);
    localparam int EW = $clog2(2*WIDTH);
    localparam int FW = WIDTH - 1;
    localparam int PW = 3*WIDTH;

    // The most negative operand maps to 2^(WIDTH-1). This value is still representable unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        magnitude = (sgn && v[WIDTH-1]) ? ((~v) + WIDTH'(1'b1)) : v;
    endfunction

    function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] mag);
        lead_one = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lead_one = mag[i] ? KW'(i) : lead_one;
        end
    endfunction

    function automatic logic [FW-1:0] fraction(input logic [WIDTH-1:0] mag, input logic [KW-1:0] k);
        logic [WIDTH-1:0] norm;
        norm     = mag << (KW'(FW) - k);
        fraction = norm[FW-1:0];
    endfunction

    logic                 r1_s, r2_s, r3_s;
    logic [WIDTH-1:0]     mag_a_s, mag_b_s;
    logic [KW-1:0]        ka_s, kb_s;
    logic                 v1_r, sign1_r, zero1_r;
    logic [KW-1:0]        ka1_r, kb1_r;
    logic [FW-1:0]        fa1_r, fb1_r;
    logic [TAG_WIDTH-1:0] tag1_r;
    logic [WIDTH-1:0]     sum_s, m_s;
    logic [EW-1:0]        e_s;
    logic                 v2_r, sign2_r, zero2_r;
    logic [WIDTH-1:0]     m2_r;
    logic [EW-1:0]        e2_r;
    logic [TAG_WIDTH-1:0] tag2_r;
    logic [2*WIDTH-1:0]   mag_p_s, prod_s;
    logic                 v3_r;

    // A stage accepts new data when it is empty or when its contents move downstream this cycle.
    always_comb begin
        r3_s = !v3_r || out_ready;
        r2_s = !v2_r || r3_s;
        r1_s = !v1_r || r2_s;
    end

    assign in_ready  = r1_s;
    assign out_valid = v3_r;

    // Stage 1 combinational path: compute operand magnitudes and leading-one positions.
    always_comb begin
        mag_a_s = magnitude(in_a, in_signed);
        mag_b_s = magnitude(in_b, in_signed);
        ka_s    = lead_one(mag_a_s);
        kb_s    = lead_one(mag_b_s);
    end

    // Stage 1 registers: the sign, zero flag, characteristics and fractions of both operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r    <= 1'b0;
            sign1_r <= 1'b0;
            zero1_r <= 1'b0;
            ka1_r   <= '0;
            kb1_r   <= '0;
            fa1_r   <= '0;
            fb1_r   <= '0;
            tag1_r  <= '0;
        end else if (r1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                sign1_r <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                zero1_r <= (mag_a_s == '0) || (mag_b_s == '0);
                ka1_r   <= ka_s;
                kb1_r   <= kb_s;
                fa1_r   <= fraction(mag_a_s, ka_s);
                fb1_r   <= fraction(mag_b_s, kb_s);
                tag1_r  <= in_tag;
            end
        end
    end

    // Stage 2 combinational path: add the logarithms. A carry out of the fraction sum raises the exponent by one.
    always_comb begin
        sum_s = {1'b0, fa1_r} + {1'b0, fb1_r};
        m_s   = {1'b1, sum_s[FW-1:0]};
        e_s   = EW'(ka1_r) + EW'(kb1_r) + EW'(sum_s[WIDTH-1]);
    end

    // Stage 2 registers: the mantissa and exponent of the log-domain sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_r    <= 1'b0;
            sign2_r <= 1'b0;
            zero2_r <= 1'b0;
            m2_r    <= '0;
            e2_r    <= '0;
            tag2_r  <= '0;
        end else if (r2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                sign2_r <= sign1_r;
                zero2_r <= zero1_r;
                m2_r    <= m_s;
                e2_r    <= e_s;
                tag2_r  <= tag1_r;
            end
        end
    end

    // Stage 3 combinational path: antilog by shifting. The shift is done in a 3*WIDTH-bit field, so no product bits are lost.
    always_comb begin
        mag_p_s = (2*WIDTH)'((PW'(m2_r) << e2_r) >> FW);
        if (zero2_r) begin
            prod_s = '0;
        end else if (sign2_r) begin
            prod_s = -mag_p_s;
        end else begin
            prod_s = mag_p_s;
        end
    end

    // Stage 3 registers drive the outputs directly. The outputs hold their value while the stage is stalled or empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            v3_r        <= 1'b0;
            out_product <= '0;
            out_tag     <= '0;
        end else if (r3_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                out_product <= prod_s;
                out_tag     <= tag2_r;
            end
        end
    end

endmodule

// File: tb/tb_app_mul_pipe.sv
// Randomized and directed bench for app_mul_pipe at WIDTH 16, 8 and 32.
// Results are scoreboarded against an arithmetic Mitchell reference model.
module tb_app_mul_pipe;

    typedef struct {
        logic [127:0] p;
        logic [3:0]   tag;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic        iv, ir, isg, ov, ordy;
    logic [15:0] ia, ib;
    logic [3:0]  itag, otag;
    logic [31:0] oprod;

    logic        iv8, ir8, isg8, ov8;
    logic [7:0]  ia8, ib8;
    logic [3:0]  itag8, otag8;
    logic [15:0] oprod8;

    logic        iv32, ir32, isg32, ov32;
    logic [31:0] ia32, ib32;
    logic [3:0]  itag32, otag32;
    logic [63:0] oprod32;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    exp_t q16[$], q8[$], q32[$];
    logic         check_lat = 1'b0;
    logic         use_dir   = 1'b0;
    logic [127:0] dir_exp;
    logic         held = 1'b0;
    logic [31:0]  held_p;
    logic [3:0]   held_t;

    app_mul_pipe #(.WIDTH(16), .TAG_WIDTH(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .in_signed(isg),
        .in_a(ia), .in_b(ib), .in_tag(itag), .out_valid(ov), .out_ready(ordy),
        .out_product(oprod), .out_tag(otag));

    app_mul_pipe #(.WIDTH(8), .TAG_WIDTH(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_signed(isg8),
        .in_a(ia8), .in_b(ib8), .in_tag(itag8), .out_valid(ov8), .out_ready(1'b1),
        .out_product(oprod8), .out_tag(otag8));

    app_mul_pipe #(.WIDTH(32), .TAG_WIDTH(4)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .in_signed(isg32),
        .in_a(ia32), .in_b(ib32), .in_tag(itag32), .out_valid(ov32), .out_ready(1'b1),
        .out_product(oprod32), .out_tag(otag32));

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, obs, expv, cyc);
        end
    endtask

    // Mitchell model: P = 2^(ka+kb) * (1+x+y) when x+y<1; otherwise P = 2^(ka+kb+1) * (x+y). The result is truncated.
    function automatic logic [127:0] mitchell(input int w, input logic sgn,
                                              input logic [63:0] a_in, input logic [63:0] b_in);
        logic [127:0] one, ma, mb, d, x, y, p;
        int ka, kb;
        logic neg;
        one = 128'd1;
        ma  = {64'd0, a_in} & ((one << w) - one);
        mb  = {64'd0, b_in} & ((one << w) - one);
        neg = 1'b0;
        if (sgn && ma[w-1]) begin ma = (one << w) - ma; neg = ~neg; end
        if (sgn && mb[w-1]) begin mb = (one << w) - mb; neg = ~neg; end
        if (ma == 128'd0 || mb == 128'd0) return 128'd0;
        ka = 0;
        kb = 0;
        for (int i = 0; i < w; i++) begin
            if (ma[i]) ka = i;
            if (mb[i]) kb = i;
        end
        d = one << (w - 1);
        x = (ma - (one << ka)) << (w - 1 - ka);
        y = (mb - (one << kb)) << (w - 1 - kb);
        if (x + y < d) p = ((d + x + y) << (ka + kb)) / d;
        else           p = ((x + y) << (ka + kb + 1)) / d;
        if (neg) p = -p;
        return p & ((one << (2 * w)) - one);
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            q16.delete();
            q8.delete();
            q32.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check_val("hold_valid", 128'(ov), 128'd1);
                check_val("hold_prod", 128'(oprod), 128'(held_p));
                check_val("hold_tag", 128'(otag), 128'(held_t));
            end
            check_val("in_ready16", 128'(ir), 128'(!(q16.size() == 3 && !ordy)));
            if (ov && ordy) begin
                check_val("q16_nonempty", 128'(q16.size() > 0), 128'd1);
                if (q16.size() > 0) begin
                    e = q16.pop_front();
                    check_val("prod16", 128'(oprod), e.p);
                    check_val("tag16", 128'(otag), 128'(e.tag));
                    if (check_lat) check_val("lat16", 128'(cyc - e.cyc), 128'd3);
                end
            end
            if (iv && ir) q16.push_back('{use_dir ? dir_exp : mitchell(16, isg, 64'(ia), 64'(ib)), itag, cyc});
            held   = ov && !ordy;
            held_p = oprod;
            held_t = otag;

            if (ov8) begin
                check_val("q8_nonempty", 128'(q8.size() > 0), 128'd1);
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    check_val("prod8", 128'(oprod8), e.p);
                    check_val("tag8", 128'(otag8), 128'(e.tag));
                    if (check_lat) check_val("lat8", 128'(cyc - e.cyc), 128'd3);
                end
            end
            if (iv8 && ir8) q8.push_back('{use_dir ? dir_exp : mitchell(8, isg8, 64'(ia8), 64'(ib8)), itag8, cyc});

            if (ov32) begin
                check_val("q32_nonempty", 128'(q32.size() > 0), 128'd1);
                if (q32.size() > 0) begin
                    e = q32.pop_front();
                    check_val("prod32", 128'(oprod32), e.p);
                    check_val("tag32", 128'(otag32), 128'(e.tag));
                    if (check_lat) check_val("lat32", 128'(cyc - e.cyc), 128'd3);
                end
            end
            if (iv32 && ir32) q32.push_back('{use_dir ? dir_exp : mitchell(32, isg32, 64'(ia32), 64'(ib32)), itag32, cyc});
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Sends one directed operation to the selected instance (8, 16 or 32) and drains the pipeline.
    task automatic send(input int which, input logic sg, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] t, input logic [127:0] expv);
        use_dir = 1'b1;
        dir_exp = expv;
        case (which)
            8:       begin iv8 = 1'b1; isg8 = sg; ia8 = a[7:0];   ib8 = b[7:0];   itag8 = t; end
            32:      begin iv32 = 1'b1; isg32 = sg; ia32 = a[31:0]; ib32 = b[31:0]; itag32 = t; end
            default: begin iv = 1'b1; isg = sg; ia = a[15:0]; ib = b[15:0]; itag = t; end
        endcase
        tick();
        iv = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
        use_dir = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [63:0] rnd_op(input int w);
        logic [63:0] r;
        r = {32'($urandom), 32'($urandom)};
        case ($urandom_range(0, 7))
            0:       r = 64'd0;
            1:       r = 64'd1 << $urandom_range(0, w - 1);
            2:       r = ~64'd0;
            default: r = r;
        endcase
        return r;
    endfunction

    task automatic rand_all(input logic en16, input logic en_wide);
        logic [63:0] a, b;
        iv = en16;
        a = rnd_op(16); b = rnd_op(16);
        ia = a[15:0]; ib = b[15:0]; isg = 1'($urandom); itag = 4'($urandom);
        iv8 = en_wide;
        a = rnd_op(8); b = rnd_op(8);
        ia8 = a[7:0]; ib8 = b[7:0]; isg8 = 1'($urandom); itag8 = 4'($urandom);
        iv32 = en_wide;
        a = rnd_op(32); b = rnd_op(32);
        ia32 = a[31:0]; ib32 = b[31:0]; isg32 = 1'($urandom); itag32 = 4'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        ordy  = 1'b1;
        iv = 1'b0; isg = 1'b0; ia = 16'd0; ib = 16'd0; itag = 4'd0;
        iv8 = 1'b0; isg8 = 1'b0; ia8 = 8'd0; ib8 = 8'd0; itag8 = 4'd0;
        iv32 = 1'b0; isg32 = 1'b0; ia32 = 32'd0; ib32 = 32'd0; itag32 = 4'd0;
        dir_exp = 128'd0;
        repeat (3) tick();
        reset = 1'b0;
        check_val("rst_valid", 128'(ov), 128'd0);
        check_val("rst_prod", 128'(oprod), 128'd0);
        check_val("rst_tag", 128'(otag), 128'd0);
        check_val("rst_in_ready", 128'(ir), 128'd1);

        check_lat = 1'b1;
        send(16, 1'b0, 64'd3, 64'd5, 4'h1, 128'd14);
        send(16, 1'b0, 64'd3, 64'd3, 4'h2, 128'd8);
        send(16, 1'b0, 64'd4, 64'd8, 4'h3, 128'd32);
        send(16, 1'b0, 64'hFFFF, 64'hFFFF, 4'h4, 128'hFFFE0000);
        send(16, 1'b0, 64'd0, 64'd1234, 4'h5, 128'd0);
        send(16, 1'b1, 64'hFFFD, 64'd5, 4'h6, 128'hFFFFFFF2);
        send(16, 1'b1, 64'h8000, 64'h8000, 4'h7, 128'h40000000);
        send(16, 1'b1, 64'hFFFF, 64'hFFFF, 4'h8, 128'd1);
        send(16, 1'b1, 64'd0, 64'hFFFB, 4'h9, 128'd0);
        send(8, 1'b0, 64'hFF, 64'hFF, 4'hA, 128'hFE00);
        send(8, 1'b1, 64'h80, 64'h01, 4'hB, 128'hFF80);
        for (int i = 0; i < 32; i += 7) begin
            send(32, 1'b0, 64'd1 << i, 64'd1 << (31 - i), 4'(i), 128'd1 << 31);
        end
        send(32, 1'b0, 64'hFFFFFFFF, 64'd1, 4'hC, 128'hFFFFFFFF);

        // Streaming: each instance receives 100 back-to-back operations with no stalls.
        for (int i = 0; i < 100; i++) begin
            rand_all(1'b1, 1'b1);
            tick();
        end
        rand_all(1'b0, 1'b0);
        repeat (5) tick();

        // Backpressure on the 16-bit instance: out_ready is randomised while in_valid stays high.
        check_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rand_all(1'b1, 1'b0);
            ordy = 1'($urandom);
            tick();
        end
        iv = 1'b0;
        ordy = 1'b1;
        repeat (5) tick();

        // Reset mid-flight: the in-flight operations must never be delivered after reset.
        check_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_all(1'b1, 1'b1);
            tick();
        end
        rand_all(1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_rst_valid", 128'(ov), 128'd0);
        check_val("mid_rst_prod", 128'(oprod), 128'd0);
        check_val("mid_rst_tag", 128'(otag), 128'd0);
        check_val("mid_rst_in_ready", 128'(ir), 128'd1);
        send(16, 1'b0, 64'd6, 64'd7, 4'hD, 128'd40);
        repeat (4) tick();

        check_val("drain16", 128'(q16.size()), 128'd0);
        check_val("drain8", 128'(q8.size()), 128'd0);
        check_val("drain32", 128'(q32.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
